// File: rtl/rom_dl_router.sv
// rom_dl_router
// Routes the HPS ioctl ROM download byte stream onto up to four SDRAM write
// ports that use toggle req/ack handshakes. Each accepted byte is matched
// against per-port address regions (lowest port wins), translated into the
// port's word address / byte strobes / duplicated data (linear or
// lane-interleaved), buffered in a small FIFO and issued strictly in order.
// Also produces dl_wait back-pressure, the rom_loaded flag, a sticky
// overflow flag and the stretched core reset.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   dl_active/wr/addr/data/index  ioctl download stream in
//   dl_wait                   back-pressure to the HPS
//   user_reset                OSD/button reset request
//   port_req/ack              per-port toggle handshake
//   port_a/ds/d               per-port word address, {hi,lo} strobes, data
//   rom_loaded, core_reset, overflow  status outputs
//   dl_sum                    16-bit wrapping sum of accepted bytes
//                             (present only with ROM_DL_CHECKSUM_EN defined)
//
// Optional feature macro: ROM_DL_CHECKSUM_EN
module rom_dl_router #(
    parameter int          NUM_PORTS   = 2,
    parameter logic [99:0] REGION_BASE = {4{25'h0}},
    parameter logic [99:0] REGION_SIZE = {4{25'h0}},
    parameter logic [3:0]  PORT_MODE   = 4'b0000,
    parameter int          ILV_BIT     = 14,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [15:0] RESET_HOLD  = 16'hFFFF
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    dl_active,
    input  logic                    dl_wr,
    input  logic [24:0]             dl_addr,
    input  logic [7:0]              dl_data,
    input  logic [7:0]              dl_index,
    output logic                    dl_wait,
    input  logic                    user_reset,
    output logic [NUM_PORTS-1:0]    port_req,
    input  logic [NUM_PORTS-1:0]    port_ack,
    output logic [NUM_PORTS*23-1:0] port_a,
    output logic [NUM_PORTS*2-1:0]  port_ds,
    output logic [NUM_PORTS*16-1:0] port_d,
    output logic                    rom_loaded,
    output logic                    core_reset,
`ifdef ROM_DL_CHECKSUM_EN
    output logic [15:0]             dl_sum,
`endif
    output logic                    overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [1:0]  port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CHECK = 1'b1} state_t;

    // capture / control registers
    logic        dl_wr_q, dl_active_q, dl_match_q, done_pend_q;
    logic        stg_valid_q;
    entry_t      stg_q;
    logic        rom_loaded_q, overflow_q, core_reset_q;
    logic [15:0] rst_cnt_q, rst_cnt_d;

    // FIFO / issue registers
    state_t                  state_q;
    entry_t                  fifo_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    dl_wait_q;
    logic [NUM_PORTS-1:0]    port_req_q;
    logic [NUM_PORTS*23-1:0] port_a_q;
    logic [NUM_PORTS*2-1:0]  port_ds_q;
    logic [NUM_PORTS*16-1:0] port_d_q;

    // combinational helpers
    logic        idx_ok_s, wr_rise_s, start_s, end_s, drained_s;
    logic        hit_s, head_idle_s, pop_s, full_s, push_ok_s, drop_s;
    logic [24:0] base_s, size_s, off_s;
    entry_t      dec_s, head_s;

    assign idx_ok_s  = (dl_index == ROM_INDEX);
    assign wr_rise_s = dl_wr && !dl_wr_q && dl_active && idx_ok_s;
    assign start_s   = dl_active && !dl_active_q && idx_ok_s;
    assign end_s     = !dl_active && dl_active_q && dl_match_q;
    assign head_s    = fifo_q[rd_ptr_q];
    assign full_s    = (count_q == FULL_LVL);
    assign pop_s     = (state_q == ST_CHECK) && head_idle_s;
    assign drained_s = (count_q == '0) && !stg_valid_q && (port_req_q == port_ack);

    // Region decode; walk ports downward so the lowest matching port is written last and wins.
    always_comb begin
        hit_s  = 1'b0;
        dec_s  = '0;
        base_s = 25'd0;
        size_s = 25'd0;
        off_s  = 25'd0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            base_s = REGION_BASE[25*p +: 25];
            size_s = REGION_SIZE[25*p +: 25];
            off_s  = dl_addr - base_s;
            // off < size (rather than addr < base+size) avoids a 25-bit wrap at the top of the map
            if ((size_s != 25'd0) && (dl_addr >= base_s) && (off_s < size_s)) begin
                hit_s      = 1'b1;
                dec_s.port = 2'(p);
                dec_s.data = dl_data;
                if (PORT_MODE[p]) begin
                    dec_s.ds = {off_s[ILV_BIT], ~off_s[ILV_BIT]};
                    dec_s.a  = {off_s[23:ILV_BIT+1], off_s[ILV_BIT-1:0]};
                end else begin
                    dec_s.ds = {off_s[0], ~off_s[0]};
                    dec_s.a  = off_s[23:1];
                end
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Head-of-queue port is free when its req and ack toggles agree.
    always_comb begin
        head_idle_s = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            head_idle_s = head_idle_s | ((head_s.port == 2'(p)) && (port_req_q[p] == port_ack[p]));
        end
    end

    // FIFO occupancy; a push into a full FIFO survives only when a pop happens in the same cycle.
    always_comb begin
        push_ok_s = stg_valid_q && (!full_s || pop_s);
        drop_s    = stg_valid_q && full_s && !pop_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Core reset counter: held at RESET_HOLD until a ROM is loaded and no user reset is requested.
    always_comb begin
        if (user_reset || !rom_loaded_q) begin
            rst_cnt_d = RESET_HOLD;
        end else if (rst_cnt_q != 16'd0) begin
            rst_cnt_d = rst_cnt_q - 16'd1;
        end else begin
            rst_cnt_d = rst_cnt_q;
        end
    end

    // Download capture, staging register, load/overflow status and reset stretch.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_q      <= 1'b0;
            dl_active_q  <= 1'b0;
            dl_match_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            stg_valid_q  <= 1'b0;
            stg_q        <= '0;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
            rst_cnt_q    <= RESET_HOLD;
            core_reset_q <= 1'b1;
        end else begin
            dl_wr_q      <= dl_wr;
            dl_active_q  <= dl_active;
            stg_valid_q  <= wr_rise_s && hit_s;
            stg_q        <= dec_s;
            rst_cnt_q    <= rst_cnt_d;
            core_reset_q <= (rst_cnt_d != 16'd0);
            if (start_s) begin
                dl_match_q   <= 1'b1;
                done_pend_q  <= 1'b0;
                rom_loaded_q <= 1'b0;
                overflow_q   <= 1'b0;
            end else begin
                if (end_s) begin
                    dl_match_q  <= 1'b0;
                    done_pend_q <= 1'b1;
                end else if (done_pend_q && drained_s) begin
                    done_pend_q  <= 1'b0;
                    rom_loaded_q <= 1'b1;
                end else begin
                    done_pend_q <= done_pend_q;
                end
                if (drop_s) begin
                    overflow_q <= 1'b1;
                end else begin
                    overflow_q <= overflow_q;
                end
            end
        end
    end

    // Write buffer plus in-order issue FSM; a busy head blocks everything behind it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dl_wait_q  <= 1'b0;
            port_req_q <= '0;
            port_a_q   <= '0;
            port_ds_q  <= '0;
            port_d_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            dl_wait_q <= (count_d >= WAIT_LVL);
            if (push_ok_s) begin
                fifo_q[wr_ptr_q] <= stg_q;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pop_s) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (head_s.port == 2'(p)) begin
                                port_a_q[23*p +: 23] <= head_s.a;
                                port_ds_q[2*p +: 2]  <= head_s.ds;
                                port_d_q[16*p +: 16] <= {head_s.data, head_s.data};
                                port_req_q[p]        <= ~port_req_q[p];
                            end
                        end
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running byte sum of region-matched download bytes, frozen once the image is loaded.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 16'd0;
        end else if (start_s) begin
            sum_q <= 16'd0;
        end else if (wr_rise_s && hit_s && !rom_loaded_q) begin
            sum_q <= sum_q + {8'd0, dl_data};
        end else begin
            sum_q <= sum_q;
        end
    end

    assign dl_sum = sum_q;
`endif

    assign dl_wait    = dl_wait_q;
    assign port_req   = port_req_q;
    assign port_a     = port_a_q;
    assign port_ds    = port_ds_q;
    assign port_d     = port_d_q;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: port0 linear at 0x0000 (32 KiB), port1 interleaved
// at 0x10000 (64 KiB, lane bit 14), 4-entry FIFO, 16-cycle reset stretch.
module tb_rom_dl_router;

    localparam int          NP  = 2;
    localparam logic [99:0] RB  = {25'h0, 25'h0, 25'h10000, 25'h0};
    localparam logic [99:0] RS  = {25'h0, 25'h0, 25'h10000, 25'h8000};
    localparam logic [3:0]  PM  = 4'b0010;
    localparam int          ILV = 14;

    typedef struct {
        int          port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        int          t;
    } txn_t;

    logic           clk_sys = 1'b0;
    logic           reset_n = 1'b0;
    logic           dl_active = 1'b0;
    logic           dl_wr = 1'b0;
    logic [24:0]    dl_addr = 25'd0;
    logic [7:0]     dl_data = 8'd0;
    logic [7:0]     dl_index = 8'd0;
    logic           dl_wait;
    logic           user_reset = 1'b0;
    logic [NP-1:0]  port_req;
    logic [NP-1:0]  port_ack = '0;
    logic [NP*23-1:0] port_a;
    logic [NP*2-1:0]  port_ds;
    logic [NP*16-1:0] port_d;
    logic           rom_loaded, core_reset, overflow;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0]    dl_sum;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_wr_t = 0;
    txn_t exp_q[$];
    txn_t obs_q[$];
    txn_t mon_t;
    logic [NP-1:0] req_prev = '0;
    logic [NP-1:0] stall = '0;
    bit   rnd_ack = 1'b0;
    int   ack_dly[NP];

    // reference region table
    int unsigned bases[NP] = '{32'h0, 32'h10000};
    int unsigned sizes[NP] = '{32'h8000, 32'h10000};
    bit          modes[NP] = '{1'b0, 1'b1};

    rom_dl_router #(
        .NUM_PORTS(NP), .REGION_BASE(RB), .REGION_SIZE(RS), .PORT_MODE(PM),
        .ILV_BIT(ILV), .FIFO_DEPTH(4), .ROM_INDEX(8'd0), .RESET_HOLD(16'd16)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_index(dl_index), .dl_wait(dl_wait),
        .user_reset(user_reset), .port_req(port_req), .port_ack(port_ack),
        .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
        .rom_loaded(rom_loaded), .core_reset(core_reset),
`ifdef ROM_DL_CHECKSUM_EN
        .dl_sum(dl_sum),
`endif
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Issue monitor: log every req toggle with the port's presented write.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            req_prev = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (port_req[p] !== req_prev[p]) begin
                    mon_t.port = p;
                    mon_t.a    = port_a[23*p +: 23];
                    mon_t.ds   = port_ds[2*p +: 2];
                    mon_t.d    = port_d[16*p +: 16];
                    mon_t.t    = cyc;
                    obs_q.push_back(mon_t);
                    req_prev[p] = port_req[p];
                end
            end
        end
    end

    // SDRAM responder: acknowledges pending requests after an optional random delay.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            port_ack = '0;
            for (int p = 0; p < NP; p++) ack_dly[p] = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (port_req[p] !== port_ack[p] && !stall[p]) begin
                    if (ack_dly[p] == 0) begin
                        port_ack[p] = ~port_ack[p];
                        ack_dly[p]  = rnd_ack ? int'($urandom_range(0, 3)) : 0;
                    end else begin
                        ack_dly[p] = ack_dly[p] - 1;
                    end
                end
            end
        end
    end

    // Reference: region lookup and address/lane translation with plain arithmetic.
    function automatic bit model(input int unsigned addr, input logic [7:0] data, output txn_t t);
        int unsigned off, word, lane;
        t.port = 0; t.a = '0; t.ds = '0; t.d = '0; t.t = 0;
        for (int p = 0; p < NP; p++) begin
            if (addr >= bases[p] && addr < bases[p] + sizes[p]) begin
                off = addr - bases[p];
                if (modes[p]) begin
                    lane = (off >> ILV) & 1;
                    word = ((off >> (ILV + 1)) << ILV) + (off % (1 << ILV));
                end else begin
                    lane = off % 2;
                    word = off / 2;
                end
                t.port = p;
                t.a    = word[22:0];
                t.ds   = (lane == 1) ? 2'b10 : 2'b01;
                t.d    = {data, data};
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk_sys); #1; end
    endtask

    task automatic do_write(input logic [24:0] addr, input logic [7:0] data, input bit accept);
        txn_t t;
        if (accept && model(int'(addr), data, t)) exp_q.push_back(t);
        last_wr_t = cyc + 1;
        dl_addr = addr;
        dl_data = data;
        dl_wr   = 1'b1;
        @(negedge clk_sys); #1;
        dl_wr = 1'b0;
        @(negedge clk_sys); #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk_sys); #1;
            k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        @(negedge clk_sys); #1;
        n_vec++; if (port_req !== 2'b00) begin n_err++; $display("FAIL reset_req got %b want 00", port_req); end
        n_vec++; if (port_a !== '0 || port_ds !== '0 || port_d !== '0) begin n_err++; $display("FAIL reset_port got a=%h ds=%h d=%h want 0", port_a, port_ds, port_d); end
        n_vec++; if (dl_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", dl_wait); end
        n_vec++; if (rom_loaded !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got loaded=%b ovf=%b want 0 0", rom_loaded, overflow); end
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL reset_core got %b want 1", core_reset); end
    endtask

    task automatic test_basic;
        bit ok;
        obs_q.delete(); exp_q.delete();
        dl_index = 8'd0; dl_active = 1'b1;
        idle(2);
        do_write(25'h0003, 8'h12, 1'b1);
        wait_obs(1, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_issue got %0d issues want 1", obs_q.size()); end
        if (ok) begin
            n_vec++; if (obs_q[0].port != 0 || obs_q[0].a !== 23'd1) begin n_err++; $display("FAIL basic_addr got p%0d a=%h want p0 a=1", obs_q[0].port, obs_q[0].a); end
            n_vec++; if (obs_q[0].ds !== 2'b10 || obs_q[0].d !== 16'h1212) begin n_err++; $display("FAIL basic_data got ds=%b d=%h want 10 1212", obs_q[0].ds, obs_q[0].d); end
            n_vec++; if (obs_q[0].t - last_wr_t != 3) begin n_err++; $display("FAIL basic_latency got %0d want 3", obs_q[0].t - last_wr_t); end
        end
    endtask

    task automatic test_interleave;
        bit ok;
        obs_q.delete(); exp_q.delete();
        do_write(25'h14005, 8'hA5, 1'b1);
        do_write(25'h18005, 8'h5A, 1'b1);
        wait_obs(2, 60, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ilv_issue got %0d issues want 2", obs_q.size()); end
        if (ok) begin
            n_vec++; if (obs_q[0].port != 1 || obs_q[0].a !== 23'h0005 || obs_q[0].ds !== 2'b10 || obs_q[0].d !== 16'hA5A5) begin
                n_err++; $display("FAIL ilv_hi got p%0d a=%h ds=%b d=%h want p1 a=0005 ds=10 d=a5a5", obs_q[0].port, obs_q[0].a, obs_q[0].ds, obs_q[0].d); end
            n_vec++; if (obs_q[1].port != 1 || obs_q[1].a !== 23'h4005 || obs_q[1].ds !== 2'b01 || obs_q[1].d !== 16'h5A5A) begin
                n_err++; $display("FAIL ilv_lo got p%0d a=%h ds=%b d=%h want p1 a=4005 ds=01 d=5a5a", obs_q[1].port, obs_q[1].a, obs_q[1].ds, obs_q[1].d); end
        end
    endtask

    task automatic test_random;
        bit ok;
        int k;
        logic [24:0] addr;
        obs_q.delete(); exp_q.delete();
        rnd_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 25'($urandom_range(0, 32'h7FFF));
                1:       addr = 25'(32'h10000 + $urandom_range(0, 32'hFFFF));
                2:       addr = 25'(32'h10000 + $urandom_range(0, 32'hFFFF));
                default: addr = 25'($urandom_range(0, 1) == 0 ? $urandom_range(32'h8000, 32'hFFFF) : $urandom_range(32'h20000, 32'h1FFFFFF));
            endcase
            k = 0;
            while (dl_wait === 1'b1 && k < 200) begin @(negedge clk_sys); #1; k++; end
            n_vec++; if (dl_wait !== 1'b0) begin n_err++; $display("FAIL rnd_wait_timeout got dl_wait=%b want 0", dl_wait); end
            do_write(addr, 8'($urandom), 1'b1);
        end
        wait_obs(exp_q.size(), 2000, ok);
        idle(10);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i].port != exp_q[i].port || obs_q[i].a !== exp_q[i].a || obs_q[i].ds !== exp_q[i].ds || obs_q[i].d !== exp_q[i].d) begin
                n_err++;
                $display("FAIL rnd_txn[%0d] got p%0d a=%h ds=%b d=%h want p%0d a=%h ds=%b d=%h", i,
                         obs_q[i].port, obs_q[i].a, obs_q[i].ds, obs_q[i].d, exp_q[i].port, exp_q[i].a, exp_q[i].ds, exp_q[i].d);
            end
        end
        rnd_ack = 1'b0;
    endtask

    task automatic test_filter;
        obs_q.delete(); exp_q.delete();
        do_write(25'h20000, 8'h77, 1'b0);
        dl_index = 8'd1;
        do_write(25'h00010, 8'h66, 1'b0);
        dl_index = 8'd0;
        idle(20);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL filter_issue got %0d issues want 0", obs_q.size()); end
        n_vec++; if (dl_wait !== 1'b0) begin n_err++; $display("FAIL filter_wait got %b want 0", dl_wait); end
    endtask

    task automatic test_back_pressure;
        bit ok;
        int tr, late;
        obs_q.delete(); exp_q.delete();
        stall[0] = 1'b1;
        do_write(25'h0100, 8'h01, 1'b1);
        do_write(25'h0101, 8'h02, 1'b1);
        do_write(25'h0202, 8'h03, 1'b1);
        n_vec++; if (dl_wait !== 1'b0) begin n_err++; $display("FAIL bp_wait2 got %b want 0", dl_wait); end
        do_write(25'h0303, 8'h04, 1'b1);
        n_vec++; if (dl_wait !== 1'b1) begin n_err++; $display("FAIL bp_wait3 got %b want 1", dl_wait); end
        do_write(25'h0404, 8'h05, 1'b1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_ovf_full got %b want 0", overflow); end
        do_write(25'h0505, 8'h06, 1'b0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf got %b want 1", overflow); end
        tr = cyc;
        stall[0] = 1'b0;
        wait_obs(5, 200, ok);
        idle(30);
        late = 0;
        foreach (obs_q[i]) if (obs_q[i].t > tr) late++;
        n_vec++; if (obs_q.size() != 5) begin n_err++; $display("FAIL bp_total got %0d want 5", obs_q.size()); end
        n_vec++; if (late != 4) begin n_err++; $display("FAIL bp_after_resume got %0d want 4", late); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i].a !== exp_q[i].a || obs_q[i].ds !== exp_q[i].ds || obs_q[i].d !== exp_q[i].d) begin
                n_err++; $display("FAIL bp_txn[%0d] got a=%h ds=%b d=%h want a=%h ds=%b d=%h", i,
                                  obs_q[i].a, obs_q[i].ds, obs_q[i].d, exp_q[i].a, exp_q[i].ds, exp_q[i].d);
            end
        end
    endtask

    task automatic test_load;
        int k, t0;
        dl_active = 1'b0;
        k = 0;
        while (rom_loaded !== 1'b1 && k < 200) begin @(negedge clk_sys); #1; k++; end
        t0 = cyc;
        n_vec++; if (rom_loaded !== 1'b1) begin n_err++; $display("FAIL load_done got %b want 1", rom_loaded); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL load_ovf_sticky got %b want 1", overflow); end
        k = 0;
        while (core_reset !== 1'b0 && k < 100) begin @(negedge clk_sys); #1; k++; end
        n_vec++; if (cyc - t0 != 16) begin n_err++; $display("FAIL load_core_release got %0d want 16", cyc - t0); end
        user_reset = 1'b1;
        @(negedge clk_sys); #1;
        user_reset = 1'b0;
        t0 = cyc;
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL user_reset_assert got %b want 1", core_reset); end
        k = 0;
        while (core_reset !== 1'b0 && k < 100) begin @(negedge clk_sys); #1; k++; end
        n_vec++; if (cyc - t0 != 16) begin n_err++; $display("FAIL user_reset_len got %0d want 16", cyc - t0); end
    endtask

    task automatic test_restart;
        dl_index = 8'd0; dl_active = 1'b1;
        idle(1);
        n_vec++; if (rom_loaded !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL restart_flags got loaded=%b ovf=%b want 0 0", rom_loaded, overflow); end
        idle(1);
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL restart_core got %b want 1", core_reset); end
    endtask

    task automatic test_async_reset;
        obs_q.delete(); exp_q.delete();
        stall = 2'b11;
        do_write(25'h0010, 8'h11, 1'b1);
        do_write(25'h0011, 8'h22, 1'b1);
        do_write(25'h0012, 8'h33, 1'b1);
        #1 reset_n = 1'b0;
        @(negedge clk_sys); #2;
        reset_n = 1'b1;
        n_vec++; if (port_req !== 2'b00) begin n_err++; $display("FAIL areset_req got %b want 00", port_req); end
        n_vec++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin n_err++; $display("FAIL areset_status got loaded=%b core=%b want 0 1", rom_loaded, core_reset); end
        n_vec++; if (dl_wait !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL areset_fifo got wait=%b ovf=%b want 0 0", dl_wait, overflow); end
        obs_q.delete();
        stall = 2'b00;
        idle(20);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL areset_flush got %0d issues want 0", obs_q.size()); end
        n_vec++; if (rom_loaded !== 1'b0) begin n_err++; $display("FAIL areset_loaded got %b want 0", rom_loaded); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_random();
        test_filter();
        test_back_pressure();
        test_load();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
